bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 128 ++++++++++++
 tb/tb_bit_serializer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//   Loads a W-bit parallel frame and shifts it out MSB first, one bit per
//   cycle when shift_en is high. x/x_valid are registered and feed a
//   downstream sequence recognizer. done pulses for one cycle when the frame
//   ends. A frame may be accepted in that same done cycle, which leaves a
//   single x_valid=0 gap between frames.
//
//   Optional feature (macro SERIALIZER_REPEAT_EN):
//     Adds input repeat_frame and a frame-save register. If repeat_frame is
//     high at the end of a frame, the saved frame is restarted at once, with
//     no gap, and done still pulses. "repeat" is a SystemVerilog keyword, so
//     the port is named repeat_frame.
//
// Parameters
//   W   frame length in bits (2..16)
//   CW  bit counter width (2**CW > W)
//
// Ports
//   CLK         clock, rising edge
//   RST         asynchronous active-low reset
//   load_data   parallel frame, MSB transmitted first
//   load_valid  load_data is offered
//   load_ready  block is idle and can accept a frame (decoded from state)
//   shift_en    advance one bit this cycle (0 = stall)
//   x           registered serial bit
//   x_valid     x carries a frame bit
//   done        one-cycle end-of-frame pulse
//   bit_count   bits emitted so far in the current frame
// ---------------------------------------------------------------------------
module bit_serializer #(
    parameter int W  = 15,
    parameter int CW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [W-1:0]  load_data,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic          shift_en,
`ifdef SERIALIZER_REPEAT_EN
    input  logic          repeat_frame,
`endif
    output logic          x,
    output logic          x_valid,
    output logic          done,
    output logic [CW-1:0] bit_count
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [CW-1:0] LAST = CW'(W);

    state_t         state;
    logic [W-1:0]   shreg;    // bits still to send, next bit in the MSB
`ifdef SERIALIZER_REPEAT_EN
    logic [W-1:0]   saved;    // copy of the accepted frame for restarts
`endif

    assign load_ready = (state == IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            shreg     <= '0;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            done      <= 1'b0;
            bit_count <= '0;
`ifdef SERIALIZER_REPEAT_EN
            saved     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        // First bit goes straight to x so it appears one cycle
                        // after accept. shreg keeps only the remaining bits.
                        x         <= load_data[W-1];
                        x_valid   <= 1'b1;
                        shreg     <= load_data << 1;
                        bit_count <= CW'(1);
                        state     <= SHIFT;
`ifdef SERIALIZER_REPEAT_EN
                        saved     <= load_data;
`endif
                    end else begin
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    // shift_en low: every register holds, done stays low.
                    if (shift_en) begin
                        if (bit_count < LAST) begin
                            x         <= shreg[W-1];
                            shreg     <= shreg << 1;
                            bit_count <= bit_count + CW'(1);
                        end else begin
                            done <= 1'b1;
`ifdef SERIALIZER_REPEAT_EN
                            if (repeat_frame) begin
                                // Restart without a gap. x_valid stays high.
                                x         <= saved[W-1];
                                shreg     <= saved << 1;
                                bit_count <= CW'(1);
                            end else begin
                                x         <= 1'b0;
                                x_valid   <= 1'b0;
                                bit_count <= '0;
                                state     <= IDLE;
                            end
`else
                            x         <= 1'b0;
                            x_valid   <= 1'b0;
                            bit_count <= '0;
                            state     <= IDLE;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer
//   Directed bench for bit_serializer (W=15). A vector table covers the basic
//   frame, with shift_en ignored in IDLE and load_data ignored in SHIFT.
//   Hand-written sequences cover stall, mid-frame reset, back-to-back frames
//   and, when SERIALIZER_REPEAT_EN is defined, frame repeat.
// ---------------------------------------------------------------------------
module tb_bit_serializer;

    localparam int W  = 15;
    localparam int CW = 5;
    localparam logic [W-1:0] FRAME = 15'b010110101101100;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [W-1:0]  load_data = '0;
    logic          load_valid = 1'b0;
    logic          shift_en = 1'b0;
    logic          load_ready;
    logic          x;
    logic          x_valid;
    logic          done;
    logic [CW-1:0] bit_count;
`ifdef SERIALIZER_REPEAT_EN
    logic          repeat_frame = 1'b0;
`endif

    bit_serializer #(.W(W), .CW(CW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
`ifdef SERIALIZER_REPEAT_EN
        .repeat_frame(repeat_frame),
`endif
        .x          (x),
        .x_valid    (x_valid),
        .done       (done),
        .bit_count  (bit_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          lv;
        logic [W-1:0]  ld;
        logic          se;
        logic          ex;
        logic          exv;
        logic          ed;
        logic          er;
        logic [CW-1:0] ebc;
    } vec_t;

    vec_t vecs [18];
    logic exp_bits [15];   // FRAME MSB first, written out by hand
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic ex, input logic exv,
                           input logic ed, input logic er, input logic [CW-1:0] ebc);
        chk({nm, ".x"},          16'(x),          16'(ex));
        chk({nm, ".x_valid"},    16'(x_valid),    16'(exv));
        chk({nm, ".done"},       16'(done),       16'(ed));
        chk({nm, ".load_ready"}, 16'(load_ready), 16'(er));
        chk({nm, ".bit_count"},  16'(bit_count),  16'(ebc));
    endtask

    // Sample 1 ns after the active edge, then drive the next inputs there.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_bits = '{0,1,0,1,1,0,1,0,1,1,0,1,1,0,0};

        // v0: shift_en in IDLE is ignored. v1: accept. v2..v15: remaining
        // bits, with load_valid and other data offered and ignored.
        // v16: done edge. v17: back to idle.
        vecs[0] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0};
        vecs[1] = '{1'b1, FRAME, 1'b1, exp_bits[0], 1'b1, 1'b0, 1'b0, 5'd1};
        for (int i = 2; i <= 15; i++)
            vecs[i] = '{1'b1, 15'h2AAA, 1'b1, exp_bits[i-1], 1'b1, 1'b0, 1'b0, CW'(i)};
        vecs[16] = '{1'b1, 15'h2AAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0};
        vecs[17] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0};

        // Reset state
        shift_en = 1'b1;
        #2;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // Basic frame from the table
        for (int i = 0; i < 18; i++) begin
            load_valid = vecs[i].lv;
            load_data  = vecs[i].ld;
            shift_en   = vecs[i].se;
            tick();
            chk_all($sformatf("basic[%0d]", i), vecs[i].ex, vecs[i].exv,
                    vecs[i].ed, vecs[i].er, vecs[i].ebc);
        end

        // Stall for 3 cycles after bit 5
        load_valid = 1'b1; load_data = FRAME; shift_en = 1'b1;
        tick();
        chk_all("stall[1]", exp_bits[0], 1'b1, 1'b0, 1'b0, 5'd1);
        load_valid = 1'b0;
        for (int k = 2; k <= 15; k++) begin
            tick();
            chk_all($sformatf("stall[%0d]", k), exp_bits[k-1], 1'b1, 1'b0, 1'b0, CW'(k));
            if (k == 5) begin
                shift_en = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk_all($sformatf("stall.hold%0d", s), exp_bits[4], 1'b1, 1'b0, 1'b0, 5'd5);
                end
                shift_en = 1'b1;
            end
        end
        tick();
        chk_all("stall.done", 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);

        // Mid-frame reset after bit 7
        load_valid = 1'b1; load_data = FRAME;
        tick();
        load_valid = 1'b0;
        for (int k = 2; k <= 7; k++) tick();
        chk_all("rst.pre", exp_bits[6], 1'b1, 1'b0, 1'b0, 5'd7);
        #2;
        RST = 1'b0;
        #1;
        chk_all("rst.async", 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_all($sformatf("rst.held%0d", c), 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        end
        @(negedge CLK);
        RST = 1'b1;
        tick();
        chk_all("rst.release", 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);

        // Back-to-back: 7FFF then 0001, load_valid held high
        load_valid = 1'b1; load_data = 15'h7FFF; shift_en = 1'b1;
        tick();
        chk_all("b2b.a1", 1'b1, 1'b1, 1'b0, 1'b0, 5'd1);
        load_data = 15'h0001;   // changes mid-frame must not leak into frame A
        for (int k = 2; k <= 15; k++) begin
            tick();
            chk_all($sformatf("b2b.a%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, CW'(k));
        end
        tick();
        chk_all("b2b.gap", 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk_all($sformatf("b2b.b%0d", k), (k == 15), 1'b1, 1'b0, 1'b0, CW'(k));
            if (k == 15) load_valid = 1'b0;
        end
        tick();
        chk_all("b2b.done", 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        tick();
        chk_all("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);

`ifdef SERIALIZER_REPEAT_EN
        // Repeat: pattern twice, no gap, done pulsed twice
        repeat_frame = 1'b1;
        load_valid = 1'b1; load_data = FRAME; shift_en = 1'b1;
        tick();
        load_valid = 1'b0;
        chk_all("rep.a1", exp_bits[0], 1'b1, 1'b0, 1'b0, 5'd1);
        for (int k = 2; k <= 15; k++) begin
            tick();
            chk_all($sformatf("rep.a%0d", k), exp_bits[k-1], 1'b1, 1'b0, 1'b0, CW'(k));
        end
        tick();
        chk_all("rep.b1", exp_bits[0], 1'b1, 1'b1, 1'b0, 5'd1);
        repeat_frame = 1'b0;
        for (int k = 2; k <= 15; k++) begin
            tick();
            chk_all($sformatf("rep.b%0d", k), exp_bits[k-1], 1'b1, 1'b0, 1'b0, CW'(k));
        end
        tick();
        chk_all("rep.done", 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
